// File: rtl/clk_burst_ctl.sv
// -----------------------------------------------------------------------------
// clk_burst_ctl
//
// Generates bursts of clock-enable ticks. The tick pattern lives in a
// downstream MC10141-style 4-bit shift register. This block loads the register
// with a 4-bit phase pattern and then rotates it right, feeding q0 back into
// the shft3in input. Every cycle in which the returned serial bit q0 is 1
// produces one tick.
//
// Ports
//   clk        : system clock; all state changes on its rising edge
//   rst_n      : asynchronous active-low reset
//   burst_req  : level request for a burst, sampled only in IDLE
//   burst_cnt  : number of ticks in the burst, latched on acceptance
//   run_mode   : 1 = free-run (count ignored, ends only on stop), latched
//   stop       : level-sensitive abort
//   pattern    : phase pattern {p0,p1,p2,p3}, latched (0000 becomes 1000)
//   q0         : serial phase bit returned by the downstream register
//   op2, op1   : downstream register mode (tMode141 encoding, op2 is MSB)
//   d0..d3     : parallel load data for the downstream register
//   shft3in    : serial input at the Q3 end (used for the right rotation)
//   shft0in    : serial input at the Q0 end (always 0, nothing shifts left)
//   burst_ack  : one-cycle pulse in the cycle a request is accepted
//   busy       : high in every state except IDLE
//   tick_en    : one-cycle clock-enable tick
//   done       : one-cycle pulse in the DONE state
//   remaining  : ticks still owed in the current burst
//   state_dbg  : current FSM state encoding (IDLE=0 LOAD=1 RUN=2 DRAIN=3 DONE=4)
//
// Handshake: a request completes in the cycle where IDLE, burst_req=1 and
// stop=0 all hold. burst_ack is high in exactly that cycle, and burst_cnt,
// run_mode and pattern are captured at the end of it. burst_req is a level
// that is looked at only in IDLE. A request held high through DONE is accepted
// again in the next IDLE cycle.
// -----------------------------------------------------------------------------
module clk_burst_ctl #(
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            burst_req,
  input  logic [CNTW-1:0] burst_cnt,
  input  logic            run_mode,
  input  logic            stop,
  input  logic [3:0]      pattern,
  input  logic            q0,
  output logic            op2,
  output logic            op1,
  output logic            d0,
  output logic            d1,
  output logic            d2,
  output logic            d3,
  output logic            shft3in,
  output logic            shft0in,
  output logic            burst_ack,
  output logic            busy,
  output logic            tick_en,
  output logic            done,
  output logic [CNTW-1:0] remaining,
  output logic [2:0]      state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // MC10141 select encoding, driven as {op2, op1}.
  typedef enum logic [1:0] {
    M_LOAD   = 2'b00,
    M_SHIFTR = 2'b01,
    M_SHIFTL = 2'b10,
    M_HOLD   = 2'b11
  } mode141_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] remaining_q;
  logic            free_run_q;
  logic [3:0]      pat_q;

  logic            accept;
  logic            tick;
  logic            last_tick;
  mode141_t        op;

  // The request is taken only in IDLE and only when no abort is pending.
  assign accept    = (state_q == S_IDLE) && burst_req && !stop;

  // In RUN the register rotates right, so q0 shows each phase bit in turn.
  assign tick      = (state_q == S_RUN) && q0;
  assign last_tick = tick && !free_run_q && (remaining_q == CNTW'(1));

  // ---------------------------------------------------------------------------
  // State register and burst context
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      free_run_q  <= 1'b0;
      pat_q       <= 4'b0000;
    end else begin
      state_q <= state_d;
      if (accept) begin
        remaining_q <= burst_cnt;
        free_run_q  <= run_mode;
        // An all-zero pattern would never tick, so it becomes a single phase.
        pat_q       <= (pattern == 4'b0000) ? 4'b1000 : pattern;
      end else if (tick && !free_run_q && (remaining_q != '0)) begin
        remaining_q <= remaining_q - CNTW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    op        = M_HOLD;
    d0        = 1'b0;
    d1        = 1'b0;
    d2        = 1'b0;
    d3        = 1'b0;
    shft3in   = 1'b0;
    shft0in   = 1'b0;
    burst_ack = 1'b0;
    busy      = 1'b1;
    tick_en   = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        // Gated by rst_n so the pulse cannot appear while reset is held.
        burst_ack = accept && rst_n;
        if (accept) begin
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        // The downstream register captures the pattern at the end of this
        // cycle, so the first phase bit reaches q0 in the first RUN cycle.
        op = M_LOAD;
        {d0, d1, d2, d3} = pat_q;
        if (stop || ((remaining_q == '0) && !free_run_q)) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        op      = M_SHIFTR;
        shft3in = q0;
        tick_en = tick;
        // A tick in the final cycle is still issued. The exit only takes
        // effect at the next edge.
        if (stop || last_tick) begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        state_d = S_DONE;
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign {op2, op1} = op;
  assign remaining  = remaining_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_clk_burst_ctl.sv
// -----------------------------------------------------------------------------
// tb_clk_burst_ctl
//
// Directed bench for clk_burst_ctl. The bench includes a small model of the
// downstream MC10141 register that closes the q0 loop. Every burst has
// hand-computed tick positions, counted in RUN cycles starting at 1, and the
// expected remaining values.
// -----------------------------------------------------------------------------
module tb_clk_burst_ctl;

  localparam int CNTW = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic            clk;
  logic            rst_n;
  logic            burst_req;
  logic [CNTW-1:0] burst_cnt;
  logic            run_mode;
  logic            stop;
  logic [3:0]      pattern;
  logic            q0;
  logic            op2, op1;
  logic            d0, d1, d2, d3;
  logic            shft3in, shft0in;
  logic            burst_ack, busy, tick_en, done;
  logic [CNTW-1:0] remaining;
  logic [2:0]      state_dbg;

  int n_cmp;
  int n_err;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  // ---------------------------------------------------------------------------
  // Clock and DUT
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  clk_burst_ctl #(.CNTW(CNTW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .burst_req (burst_req),
    .burst_cnt (burst_cnt),
    .run_mode  (run_mode),
    .stop      (stop),
    .pattern   (pattern),
    .q0        (q0),
    .op2       (op2),
    .op1       (op1),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .shft3in   (shft3in),
    .shft0in   (shft0in),
    .burst_ack (burst_ack),
    .busy      (busy),
    .tick_en   (tick_en),
    .done      (done),
    .remaining (remaining),
    .state_dbg (state_dbg)
  );

  // Downstream MC10141 model: ds_q[i] is Qi. Shift right moves Q3 toward Q0
  // and shifts shft3in in at Q3.
  logic [3:0] ds_q;
  initial ds_q = 4'b0000;
  always @(posedge clk) begin
    case ({op2, op1})
      2'b00:   ds_q <= {d3, d2, d1, d0};
      2'b01:   ds_q <= {shft3in, ds_q[3:1]};
      2'b10:   ds_q <= {ds_q[2:0], shft0in};
      default: ds_q <= ds_q;
    endcase
  end
  assign q0 = ds_q[0];

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic compare_q(input string tag);
    check_eq({tag, "/count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check_eq($sformatf("%s/item%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "/state"}, 32'(state_dbg), 32'(ST_IDLE));
    check_eq({tag, "/op"}, 32'({op2, op1}), 32'd3);
    check_eq({tag, "/remaining"}, 32'(remaining), 32'd0);
    check_eq({tag, "/outs"},
             32'({d0, d1, d2, d3, shft3in, shft0in, burst_ack, busy, tick_en, done}),
             32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one complete burst. Called at a sample point while the DUT is idle.
  // ---------------------------------------------------------------------------
  task automatic run_burst(input string tag, input logic [7:0] cnt, input logic mode,
                           input logic [3:0] pat, input logic [3:0] exp_d,
                           input int stop_at, input logic [7:0] exp_rem_end);
    int   run_cyc;
    int   t;
    int   drain_t;
    int   last_tick_t;
    int   rem_err;
    int   aux_err;
    logic saw_done;
    logic [7:0] exp_rem;

    got_q.delete();
    burst_req = 1'b1;
    burst_cnt = cnt;
    run_mode  = mode;
    pattern   = pat;
    stop      = 1'b0;
    #1;
    check_eq({tag, "/ack"}, 32'(burst_ack), 32'd1);

    @(posedge clk); #1;
    // Scramble the inputs so that only the latched copies can be used.
    burst_req = 1'b0;
    burst_cnt = 8'hA5;
    run_mode  = ~mode;
    pattern   = 4'b0101;
    check_eq({tag, "/load_state"}, 32'(state_dbg), 32'(ST_LOAD));
    check_eq({tag, "/load_op"}, 32'({op2, op1}), 32'd0);
    check_eq({tag, "/load_d"}, 32'({d0, d1, d2, d3}), 32'(exp_d));
    check_eq({tag, "/load_rem"}, 32'(remaining), 32'(cnt));
    check_eq({tag, "/load_ack"}, 32'({burst_ack, busy}), 32'b01);

    run_cyc = 0; t = 0; drain_t = -10; last_tick_t = -100;
    rem_err = 0; aux_err = 0; saw_done = 1'b0;
    while (!saw_done && t < 300) begin
      @(posedge clk); #1;
      t++;
      case (state_dbg)
        ST_RUN: begin
          run_cyc++;
          exp_rem = mode ? cnt : cnt - 8'(got_q.size());
          if (remaining !== exp_rem) rem_err++;
          if ({op2, op1} !== 2'b01 || shft3in !== q0 || shft0in !== 1'b0 ||
              {d0, d1, d2, d3} !== 4'b0000 || done !== 1'b0 || busy !== 1'b1)
            aux_err++;
          if (tick_en) begin
            got_q.push_back(8'(run_cyc));
            last_tick_t = t;
          end
          if (run_cyc == stop_at) stop = 1'b1;
        end
        ST_DRAIN: begin
          drain_t = t;
          stop = 1'b0;
          if ({op2, op1} !== 2'b11 || tick_en !== 1'b0 || done !== 1'b0 ||
              {d0, d1, d2, d3, shft3in, shft0in} !== 6'd0 || busy !== 1'b1)
            aux_err++;
        end
        ST_DONE: begin
          saw_done = 1'b1;
          check_eq({tag, "/done"}, 32'({done, busy, tick_en}), 32'b110);
          check_eq({tag, "/drain_to_done"}, 32'(t - drain_t), 32'd1);
        end
        default: aux_err++;
      endcase
    end
    stop = 1'b0;
    check_eq({tag, "/reached_done"}, 32'(saw_done), 32'd1);
    check_eq({tag, "/remaining_track"}, 32'(rem_err), 32'd0);
    check_eq({tag, "/run_outputs"}, 32'(aux_err), 32'd0);
    compare_q({tag, "/ticks"});
    if (got_q.size() > 0)
      check_eq({tag, "/last_tick_to_done"}, 32'(t - last_tick_t), 32'd2);
    check_eq({tag, "/rem_end"}, 32'(remaining), 32'(exp_rem_end));

    @(posedge clk); #1;
    check_eq({tag, "/idle_after"}, 32'({state_dbg, busy, done}), 32'({ST_IDLE, 2'b00}));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int t;
    int tick_cnt;
    int busy_cnt;
    logic reached;

    n_cmp = 0;
    n_err = 0;
    rst_n     = 1'b0;
    burst_req = 1'b0;
    burst_cnt = '0;
    run_mode  = 1'b0;
    stop      = 1'b0;
    pattern   = 4'b0000;

    // Reset values
    #1;
    check_quiet("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("idle");

    // A request with stop asserted must be refused
    burst_req = 1'b1;
    burst_cnt = 8'd3;
    pattern   = 4'b1000;
    stop      = 1'b1;
    #1;
    check_eq("stop_idle/ack", 32'(burst_ack), 32'd0);
    @(posedge clk); #1;
    check_eq("stop_idle/state", 32'(state_dbg), 32'(ST_IDLE));
    burst_req = 1'b0;
    stop      = 1'b0;

    // cnt=3, pattern 1000: ticks on RUN cycles 1, 5, 9
    exp_q = '{8'd1, 8'd5, 8'd9};
    run_burst("cnt3", 8'd3, 1'b0, 4'b1000, 4'b1000, 0, 8'd0);

    // cnt=4, pattern 1010: ticks on RUN cycles 1, 3, 5, 7
    exp_q = '{8'd1, 8'd3, 8'd5, 8'd7};
    run_burst("cnt4", 8'd4, 1'b0, 4'b1010, 4'b1010, 0, 8'd0);

    // cnt=0: LOAD goes straight to DRAIN with no ticks
    exp_q.delete();
    run_burst("cnt0", 8'd0, 1'b0, 4'b1111, 4'b1111, 0, 8'd0);

    // Free-run, pattern 1111, stop in RUN cycle 10: ticks 1..10, count frozen
    exp_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10};
    run_burst("freerun", 8'd7, 1'b1, 4'b1111, 4'b1111, 10, 8'd7);

    // A zero pattern behaves as 1000
    exp_q = '{8'd1, 8'd5};
    run_burst("pat0", 8'd2, 1'b0, 4'b0000, 4'b1000, 0, 8'd0);

    // Request held through DONE: acks only in IDLE, at offsets 0 and 5
    burst_req = 1'b1;
    burst_cnt = 8'd1;
    run_mode  = 1'b0;
    pattern   = 4'b1000;
    got_q.delete();
    exp_q = '{8'd0, 8'd5};
    for (int k = 0; k < 8; k++) begin
      #1;
      if (burst_ack) got_q.push_back(8'(k));
      if (burst_ack && state_dbg !== ST_IDLE) got_q.push_back(8'hEE);
      @(posedge clk);
    end
    compare_q("b2b/acks");
    #1;
    burst_req = 1'b0;
    reached = 1'b0;
    for (int k = 0; k < 40 && !reached; k++) begin
      @(posedge clk); #1;
      if (state_dbg == ST_IDLE) reached = 1'b1;
    end
    check_eq("b2b/back_to_idle", 32'(reached), 32'd1);

    // Reset during RUN with remaining=5
    burst_req = 1'b1;
    burst_cnt = 8'd5;
    run_mode  = 1'b0;
    pattern   = 4'b1111;
    @(posedge clk); #1;
    burst_req = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_run/pre_state", 32'(state_dbg), 32'(ST_RUN));
    check_eq("rst_run/pre_rem", 32'(remaining), 32'd5);
    rst_n = 1'b0;
    #1;
    check_quiet("rst_run/async");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick_cnt = 0;
    busy_cnt = 0;
    for (t = 0; t < 20; t++) begin
      @(posedge clk); #1;
      if (tick_en) tick_cnt++;
      if (busy) busy_cnt++;
    end
    check_eq("rst_run/no_ticks", 32'(tick_cnt), 32'd0);
    check_eq("rst_run/no_busy", 32'(busy_cnt), 32'd0);
    check_quiet("rst_run/idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
